// File: rtl/uart_fifo_v2.sv
// uart_fifo_v2: parametrised show-ahead byte FIFO for the UART TX/RX paths.
// Supports any depth >= 2 with full FIFO_SIZE occupancy, programmable
// almost-full/almost-empty watermarks and, when UART_FIFO_ERR_FLAGS_EN is
// defined, sticky overflow/underflow flags cleared by err_clear or sync_reset.
module uart_fifo_v2 #(
    parameter int unsigned FIFO_SIZE = 4,
    parameter int unsigned WIDTH     = 8,
    localparam int unsigned CNT_W    = $clog2(FIFO_SIZE + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sync_reset,
    input  logic             fifo_write,
    input  logic [WIDTH-1:0] fifo_data_in,
    input  logic             fifo_read,
    output logic [WIDTH-1:0] fifo_top_data_out,
    output logic             fifo_not_empty,
    output logic             fifo_full,
    output logic [CNT_W-1:0] fifo_count,
    input  logic [CNT_W-1:0] afull_level,
    input  logic [CNT_W-1:0] aempty_level,
    output logic             fifo_almost_full,
    output logic             fifo_almost_empty,
    input  logic             err_clear,
    output logic             fifo_overflow,
    output logic             fifo_underflow
);

    localparam int unsigned PTR_W = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_SIZE);

    logic [WIDTH-1:0] mem_q [FIFO_SIZE];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rd_ok_c, wr_ok_c;

    // Wrap at FIFO_SIZE-1 by compare so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Acceptance and next-state for pointers and occupancy.
    always_comb begin
        rd_ok_c  = fifo_read & (count_q != '0);
        wr_ok_c  = fifo_write & ((count_q != CNT_FULL) | rd_ok_c);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (sync_reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok_c) wr_ptr_d = ptr_next(wr_ptr_q);
            if (rd_ok_c) rd_ptr_d = ptr_next(rd_ptr_q);
            case ({wr_ok_c, rd_ok_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

`ifdef UART_FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // Sticky error flags; a new event in the same cycle as err_clear wins.
    always_comb begin
        ovf_d = err_clear ? 1'b0 : ovf_q;
        unf_d = err_clear ? 1'b0 : unf_q;
        if (fifo_write & ~wr_ok_c) ovf_d = 1'b1;
        if (fifo_read & ~rd_ok_c)  unf_d = 1'b1;
        if (sync_reset) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    assign fifo_overflow  = ovf_q;
    assign fifo_underflow = unf_q;
`else
    logic unused_err_clear;
    assign unused_err_clear = err_clear;
    assign fifo_overflow    = 1'b0;
    assign fifo_underflow   = 1'b0;
`endif

    // Pointer, count and error-flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef UART_FIFO_ERR_FLAGS_EN
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifdef UART_FIFO_ERR_FLAGS_EN
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
`endif
        end
    end

    // Storage is not reset; only accepted writes touch an entry.
    always_ff @(posedge clk) begin
        if (wr_ok_c && !sync_reset) mem_q[wr_ptr_q] <= fifo_data_in;
    end

    // Show-ahead head and count-derived flags.
    assign fifo_top_data_out = mem_q[rd_ptr_q];
    assign fifo_count        = count_q;
    assign fifo_not_empty    = (count_q != '0);
    assign fifo_full         = (count_q == CNT_FULL);
    assign fifo_almost_full  = (count_q >= afull_level);
    assign fifo_almost_empty = (count_q <= aempty_level);

endmodule

// File: tb/tb_uart_fifo_v2.sv
// tb_uart_fifo_v2: directed plus randomized checks of uart_fifo_v2 (FIFO_SIZE = 5)
// against a queue-based reference model. Honors UART_FIFO_ERR_FLAGS_EN.
module tb_uart_fifo_v2;

    localparam int unsigned N     = 5;
    localparam int unsigned W     = 8;
    localparam int unsigned CW    = $clog2(N + 1);
`ifdef UART_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sync_reset;
    logic          fifo_write;
    logic [W-1:0]  fifo_data_in;
    logic          fifo_read;
    logic [W-1:0]  fifo_top_data_out;
    logic          fifo_not_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] afull_level;
    logic [CW-1:0] aempty_level;
    logic          fifo_almost_full;
    logic          fifo_almost_empty;
    logic          err_clear;
    logic          fifo_overflow;
    logic          fifo_underflow;

    uart_fifo_v2 #(.FIFO_SIZE(N), .WIDTH(W)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .sync_reset        (sync_reset),
        .fifo_write        (fifo_write),
        .fifo_data_in      (fifo_data_in),
        .fifo_read         (fifo_read),
        .fifo_top_data_out (fifo_top_data_out),
        .fifo_not_empty    (fifo_not_empty),
        .fifo_full         (fifo_full),
        .fifo_count        (fifo_count),
        .afull_level       (afull_level),
        .aempty_level      (aempty_level),
        .fifo_almost_full  (fifo_almost_full),
        .fifo_almost_empty (fifo_almost_empty),
        .err_clear         (err_clear),
        .fifo_overflow     (fifo_overflow),
        .fifo_underflow    (fifo_underflow)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: a queue of entries plus two sticky bits.
    logic [W-1:0] mq[$];
    bit           m_ovf = 1'b0;
    bit           m_unf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int unsigned c;
        c = mq.size();
        chk({tag, ":count"}, 32'(fifo_count), 32'(c));
        chk({tag, ":not_empty"}, 32'(fifo_not_empty), 32'(c != 0));
        chk({tag, ":full"}, 32'(fifo_full), 32'(c == N));
        chk({tag, ":afull"}, 32'(fifo_almost_full), 32'(c >= int'(afull_level)));
        chk({tag, ":aempty"}, 32'(fifo_almost_empty), 32'(c <= int'(aempty_level)));
        chk({tag, ":ovf"}, 32'(fifo_overflow), 32'(m_ovf));
        chk({tag, ":unf"}, 32'(fifo_underflow), 32'(m_unf));
        if (c != 0) chk({tag, ":head"}, 32'(fifo_top_data_out), 32'(mq[0]));
    endtask

    // One clock: drive, check read data in-cycle, clock, update model, check.
    task automatic step(input string tag, input bit w, input logic [W-1:0] d,
                        input bit r, input bit clr, input bit srst);
        bit rd_ok, wr_ok;
        fifo_write   = w;
        fifo_data_in = d;
        fifo_read    = r;
        err_clear    = clr;
        sync_reset   = srst;
        rd_ok = r && (mq.size() != 0);
        wr_ok = w && ((mq.size() < N) || rd_ok);
        #1;
        if (rd_ok) chk({tag, ":rd_data"}, 32'(fifo_top_data_out), 32'(mq[0]));
        @(posedge clk);
        #1;
        if (srst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (rd_ok) void'(mq.pop_front());
            if (wr_ok) mq.push_back(d);
            if (ERR_EN) begin
                m_ovf = (clr ? 1'b0 : m_ovf) | (w & !wr_ok);
                m_unf = (clr ? 1'b0 : m_unf) | (r & !rd_ok);
            end
        end
        fifo_write = 1'b0;
        fifo_read  = 1'b0;
        err_clear  = 1'b0;
        sync_reset = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [4:0] ae_exp;
        logic [4:0] af_exp;
        reset_n      = 1'b0;
        sync_reset   = 1'b0;
        fifo_write   = 1'b0;
        fifo_data_in = '0;
        fifo_read    = 1'b0;
        err_clear    = 1'b0;
        afull_level  = CW'(3);
        aempty_level = CW'(1);
        #12;
        check_all("reset");
        chk("reset_aempty", 32'(fifo_almost_empty), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Fill 1..5 then drain in order.
        for (int i = 1; i <= 5; i++) step("fill", 1'b1, W'(i), 1'b0, 1'b0, 1'b0);
        chk("fill_full", 32'(fifo_full), 32'd1);
        chk("fill_count", 32'(fifo_count), 32'd5);
        for (int i = 1; i <= 5; i++) begin
            chk("drain_order", 32'(fifo_top_data_out), 32'(i));
            step("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        chk("drain_count", 32'(fifo_count), 32'd0);

        // Refill with wrapped pointers, then full + read + write.
        for (int i = 0; i < 5; i++) step("refill", 1'b1, W'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        chk("full_rw_head_before", 32'(fifo_top_data_out), 32'h10);
        step("full_rw", 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        chk("full_rw_count", 32'(fifo_count), 32'd5);
        chk("full_rw_ovf", 32'(fifo_overflow), 32'd0);
        for (int i = 0; i < 5; i++) step("drain2", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Empty + read + write: write accepted, read ignored.
        step("empty_rw", 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        chk("empty_rw_count", 32'(fifo_count), 32'd1);
        chk("empty_rw_head", 32'(fifo_top_data_out), 32'h3C);
        chk("empty_rw_unf", 32'(fifo_underflow), 32'(ERR_EN));
        step("unf_clear", 1'b0, '0, 1'b1, 1'b1, 1'b0);

        // Watermark walk 0..4 with afull=3, aempty=1.
        ae_exp = 5'b00011;
        af_exp = 5'b11000;
        chk("wm_ae0", 32'(fifo_almost_empty), 32'(ae_exp[0]));
        chk("wm_af0", 32'(fifo_almost_full), 32'(af_exp[0]));
        for (int i = 1; i <= 4; i++) begin
            step("wm", 1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
            chk("wm_ae", 32'(fifo_almost_empty), 32'(ae_exp[i]));
            chk("wm_af", 32'(fifo_almost_full), 32'(af_exp[i]));
        end

        // Overflow: dropped write, clear, clear + new overflow.
        step("to_full", 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        step("ovf", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", 32'(fifo_overflow), 32'(ERR_EN));
        step("ovf_clr", 1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("ovf_cleared", 32'(fifo_overflow), 32'd0);
        step("ovf_clr_set", 1'b1, 8'hEF, 1'b0, 1'b1, 1'b0);
        chk("ovf_clr_set", 32'(fifo_overflow), 32'(ERR_EN));

        // Async reset mid-burst at count 3.
        step("sr_flush", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step("burst", 1'b1, W'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        chk("areset_count", 32'(fifo_count), 32'd0);
        chk("areset_ne", 32'(fifo_not_empty), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // sync_reset overrides a same-cycle write.
        step("pre_sr", 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        step("sr_write", 1'b1, 8'h78, 1'b0, 1'b0, 1'b1);
        chk("sr_write_count", 32'(fifo_count), 32'd0);

        // Randomized traffic with varying watermark levels.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                afull_level  = CW'($urandom_range(0, 7));
                aempty_level = CW'($urandom_range(0, 7));
            end
            step("rand", 1'($urandom), W'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
